// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// State encoding, width helpers and default ack timeout.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  localparam int ACK_TIMEOUT_DEF = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int id_w(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and uart_tx side signals of the transmit arbiter.
// master = arbiter view, slave = requesters plus uart_tx view.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic               uart_start;
  logic [7:0]         uart_data;
  logic               uart_busy;

  modport master (
    input  req_valid, req_data, req_last,
    input  uart_busy,
    output req_ready, uart_start, uart_data
  );

  modport slave (
    output req_valid, req_data, req_last,
    output uart_busy,
    input  req_ready, uart_start, uart_data
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first set request after ptr, wrapping.
// Purely combinational; returns hit, index and one-hot grant.
module uart_tx_arbiter_rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDW   = id_w(N_REQ)
)(
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic             hit,
  output logic [IDW-1:0]   idx,
  output logic [N_REQ-1:0] onehot
);

  // Scan farthest-first so the nearest hit after ptr wins.
  always_comb begin
    logic [IDW-1:0] j;
    hit = 1'b0;
    idx = '0;
    j   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      j = IDW'((int'(ptr) + k) % N_REQ);
      if (req[j]) begin
        hit = 1'b1;
        idx = j;
      end
    end
    onehot = hit ? (N_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between N_REQ byte producers.
// Round-robin per message, optional lock, ack timeout.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
  parameter bit LOCK_EN     = 1'b1,
  localparam int IDW        = id_w(N_REQ),
  localparam int CW         = clog2(ACK_TIMEOUT + 1)
)(
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.master bus,
  output logic              grant_valid,
  output logic [IDW-1:0]    grant_id,
  output logic              ack_err
);

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic             lock;
  logic             last_q;
  logic [CW-1:0]    cnt;

  logic             pick_hit;
  logic [IDW-1:0]   pick_idx;
  logic [N_REQ-1:0] pick_oh;

  logic             hold;
  logic             win_hit;
  logic [IDW-1:0]   win_id;
  logic [N_REQ-1:0] win_oh;
  logic             lock_next;

  uart_tx_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_pick (
    .req    (bus.req_valid),
    .ptr    (rr_ptr),
    .hit    (pick_hit),
    .idx    (pick_idx),
    .onehot (pick_oh)
  );

  // A held lock overrides round-robin only while its owner stays valid.
  always_comb begin
    hold      = lock && bus.req_valid[grant_id];
    win_hit   = hold || pick_hit;
    win_id    = hold ? grant_id : pick_idx;
    win_oh    = hold ? (N_REQ'(1) << grant_id) : pick_oh;
    lock_next = LOCK_EN && !last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      bus.req_ready  <= '0;
      bus.uart_start <= 1'b0;
      bus.uart_data  <= 8'h00;
      grant_valid    <= 1'b0;
      grant_id       <= '0;
      ack_err        <= 1'b0;
      rr_ptr         <= IDW'(N_REQ - 1);
      lock           <= 1'b0;
      last_q         <= 1'b0;
      cnt            <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!bus.uart_busy) begin
            if (lock && !hold) begin
              lock        <= 1'b0;
              grant_valid <= 1'b0;
            end
            if (win_hit) begin
              bus.uart_data  <= bus.req_data[{win_id, 3'b000} +: 8];
              last_q         <= bus.req_last[win_id];
              grant_id       <= win_id;
              grant_valid    <= 1'b1;
              bus.uart_start <= 1'b1;
              bus.req_ready  <= win_oh;
              state          <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          bus.uart_start <= 1'b0;
          bus.req_ready  <= '0;
          cnt            <= '0;
          state          <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (bus.uart_busy) begin
            state <= WAIT_DONE;
          end else if (cnt >= CW'(ACK_TIMEOUT - 1)) begin
            ack_err     <= 1'b1;
            lock        <= 1'b0;
            grant_valid <= 1'b0;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!bus.uart_busy) begin
            rr_ptr      <= grant_id;
            lock        <= lock_next;
            grant_valid <= lock_next;
            state       <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
